mem_responder: RTL and testbench

Byte-wide memory and I/O responder on the device side of the CPU memory bus, facing `memory_controller`. It serves 1-cycle-latency byte reads and writes to a synchronous RAM. It decodes a small I/O window: a UART transmit FIFO, a receive holding byte and a program-end flag. It drives `io_buffer_full` back to the controller as store back-pressure.

---
 rtl/mem_responder_pkg.sv | 10 +
 rtl/io_tx_fifo.sv | 40 ++++
 rtl/mem_responder.sv | 71 +++++++
 tb/tb_mem_responder.sv | 137 +++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: address map and decode shared by the memory/IO responder
package mem_responder_pkg;
  localparam logic [17:0] IO_DATA_ADDR = 18'h30000;
  localparam logic [17:0] IO_END_ADDR = 18'h30004;
  localparam int IO_SPACE_BIT = 17;
  typedef enum logic [1:0] {DEC_RAM, DEC_IO_DATA, DEC_IO_END, DEC_UNMAPPED} decode_t;
  function automatic decode_t decode(input logic [17:0] a);
    return !a[IO_SPACE_BIT] ? DEC_RAM : a == IO_DATA_ADDR ? DEC_IO_DATA : a == IO_END_ADDR ? DEC_IO_END : DEC_UNMAPPED;
  endfunction
endpackage

// File: rtl/io_tx_fifo.sv
// io_tx_fifo: UART transmit FIFO with registered near-full flag
module io_tx_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int FULL_MARGIN = 2
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       near_full
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] THRESH = (AW + 1)'(FIFO_DEPTH - FULL_MARGIN);
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt, cnt_nx;
  logic pop;
  assign tx_valid = cnt != '0;
  assign tx_data = mem[rp];
  assign pop = tx_valid && tx_ready;
  assign cnt_nx = cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      near_full <= 1'b0;
    end else begin
      wp <= push ? wp + 1'b1 : wp;
      rp <= pop ? rp + 1'b1 : rp;
      cnt <= cnt_nx;
      near_full <= cnt_nx >= THRESH;
    end
  end
  always_ff @(posedge clk_in)
    if (push) mem[wp] <= push_data;
endmodule

// File: rtl/mem_responder.sv
// mem_responder: byte RAM + UART I/O responder; define MEM_RESPONDER_RX_EN for the RX holding register
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int FIFO_DEPTH = 16,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] cpu_a,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        program_end
);
  logic [7:0] ram [2**RAM_ADDR_WIDTH];
  decode_t dec;
  logic push, rd_io;
  logic [7:0] rx_byte_out;
  assign dec = decode(cpu_a[17:0]);
  assign push = cpu_wr && dec == DEC_IO_DATA && !io_buffer_full && !rst_in;
  assign rd_io = !cpu_wr && dec == DEC_IO_DATA;
  io_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .FULL_MARGIN(FULL_MARGIN)) u_fifo (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .push(push),
    .push_data(cpu_dout),
    .tx_ready(tx_ready),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .near_full(io_buffer_full)
  );
`ifdef MEM_RESPONDER_RX_EN
  logic rx_full;
  logic [7:0] rx_byte;
  assign rx_ready = !rx_full;
  assign rx_byte_out = rx_full ? rx_byte : 8'h00;
  always_ff @(posedge clk_in) begin
    if (rst_in) rx_full <= 1'b0;
    else if (rx_valid && rx_ready) rx_full <= 1'b1;
    else if (rd_io) rx_full <= 1'b0;
    if (rx_valid && rx_ready) rx_byte <= rx_data;
  end
  logic unused_hi;
  assign unused_hi = ^cpu_a[31:18];
`else
  assign rx_ready = 1'b0;
  assign rx_byte_out = 8'h00;
  logic unused_rx;
  assign unused_rx = ^{rx_data, rx_valid, cpu_a[31:18]};
`endif
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cpu_din <= 8'h00;
      program_end <= 1'b0;
    end else begin
      cpu_din <= dec == DEC_RAM ? ram[cpu_a[RAM_ADDR_WIDTH-1:0]] : rd_io ? rx_byte_out : 8'h00;
      program_end <= program_end || (cpu_wr && dec == DEC_IO_END);
    end
  end
  always_ff @(posedge clk_in)
    if (!rst_in && cpu_wr && dec == DEC_RAM) ram[cpu_a[RAM_ADDR_WIDTH-1:0]] <= cpu_dout;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed self-checking bench for mem_responder
module tb_mem_responder;
  logic clk_in = 1'b0, rst_in;
  logic [31:0] cpu_a;
  logic cpu_wr, tx_ready, rx_valid;
  logic [7:0] cpu_dout, rx_data;
  logic [7:0] cpu_din, tx_data;
  logic io_buffer_full, tx_valid, rx_ready, program_end;
  int errors = 0, checks = 0;
  logic [7:0] q[$];
  logic [7:0] d;
  mem_responder dut (
    .clk_in(clk_in), .rst_in(rst_in), .cpu_a(cpu_a), .cpu_wr(cpu_wr), .cpu_dout(cpu_dout),
    .cpu_din(cpu_din), .io_buffer_full(io_buffer_full), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .program_end(program_end)
  );
  always #5 clk_in = ~clk_in;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask
  task automatic acc(input logic [31:0] a, input logic wr, input logic [7:0] dat);
    cpu_a = a;
    cpu_wr = wr;
    cpu_dout = dat;
    cyc();
  endtask
  initial begin
    rst_in = 1'b1; cpu_a = 32'hFFFFFFFF; cpu_wr = 1'b0; cpu_dout = 8'h00;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    cyc(); cyc();
    rst_in = 1'b0;
    chk("rst_din", cpu_din, 8'h00);
    chk("rst_full", io_buffer_full, 1'b0);
    chk("rst_txv", tx_valid, 1'b0);
    chk("rst_end", program_end, 1'b0);
`ifdef MEM_RESPONDER_RX_EN
    chk("rst_rxr", rx_ready, 1'b1);
`else
    chk("rst_rxr", rx_ready, 1'b0);
`endif
    acc(32'h00010, 1'b1, 8'hA5);
    acc(32'h00010, 1'b0, 8'h00);
    chk("ram_lat", cpu_din, 8'hA5);
    acc(32'h00020, 1'b1, 8'h11);
    acc(32'h00020, 1'b1, 8'h22);
    chk("rd_first_old", cpu_din, 8'h11);
    acc(32'h00020, 1'b0, 8'h00);
    chk("rd_first_new", cpu_din, 8'h22);
    acc(32'h20010, 1'b1, 8'h77);
    acc(32'h20010, 1'b0, 8'h00);
    chk("unmapped_rd", cpu_din, 8'h00);
    acc(32'h00010, 1'b0, 8'h00);
    chk("unmapped_wr_ignored", cpu_din, 8'hA5);
    for (int i = 0; i < 14; i++) begin
      acc(32'h30000, 1'b1, 8'h40 + 8'(i));
      if (i == 0) chk("push_vis", {tx_valid, tx_data}, {1'b1, 8'h40});
      if (i == 12) chk("full_13", io_buffer_full, 1'b0);
    end
    chk("full_14", io_buffer_full, 1'b1);
    for (int i = 0; i < 5; i++) acc(32'h30000, 1'b1, 8'hEE);
    chk("full_held", io_buffer_full, 1'b1);
    cpu_a = 32'hFFFFFFFF; cpu_wr = 1'b0;
    tx_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      chk("drain", {tx_valid, tx_data}, {1'b1, 8'h40 + 8'(i)});
      cyc();
      if (i == 0) chk("full_fall", io_buffer_full, 1'b0);
    end
    chk("drain_empty", tx_valid, 1'b0);
    tx_ready = 1'b0;
    d = 8'h80;
    for (int i = 0; i < 3; i++) begin
      q.push_back(d);
      acc(32'h30000, 1'b1, d);
      d++;
    end
    tx_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      chk("pp_order", {tx_valid, tx_data}, {1'b1, q[0]});
      void'(q.pop_front());
      q.push_back(d);
      acc(32'h30000, 1'b1, d);
      d++;
    end
    chk("pp_full", io_buffer_full, 1'b0);
    cpu_a = 32'hFFFFFFFF; cpu_wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("pp_tail", {tx_valid, tx_data}, {1'b1, q[0]});
      void'(q.pop_front());
      cyc();
    end
    chk("pp_count3", tx_valid, 1'b0);
    tx_ready = 1'b0;
    acc(32'h30004, 1'b1, 8'h01);
    chk("end_set", program_end, 1'b1);
    acc(32'h30004, 1'b0, 8'h00);
    chk("end_rd", cpu_din, 8'h00);
    for (int i = 0; i < 3; i++) acc(32'hFFFFFFFF, 1'b0, 8'h00);
    chk("pause_side", {program_end, tx_valid, cpu_din}, {1'b1, 1'b0, 8'h00});
    acc(32'h00020, 1'b0, 8'h00);
    chk("pause_ram", cpu_din, 8'h22);
    rx_data = 8'h5A; rx_valid = 1'b1;
    acc(32'hFFFFFFFF, 1'b0, 8'h00);
    rx_valid = 1'b0;
`ifdef MEM_RESPONDER_RX_EN
    chk("rx_busy", rx_ready, 1'b0);
    acc(32'h30000, 1'b0, 8'h00);
    chk("rx_rd1", cpu_din, 8'h5A);
    chk("rx_ready_back", rx_ready, 1'b1);
    acc(32'h30000, 1'b0, 8'h00);
    chk("rx_rd2", cpu_din, 8'h00);
`else
    acc(32'h30000, 1'b0, 8'h00);
    chk("rx_off_rd", cpu_din, 8'h00);
    chk("rx_off_ready", rx_ready, 1'b0);
`endif
    acc(32'h30000, 1'b1, 8'h99);
    acc(32'h30000, 1'b1, 8'h9A);
    rst_in = 1'b1;
    acc(32'h30000, 1'b1, 8'h9B);
    chk("mid_rst", {tx_valid, io_buffer_full, program_end, cpu_din}, {3'b000, 8'h00});
    rst_in = 1'b0;
    acc(32'hFFFFFFFF, 1'b0, 8'h00);
    chk("post_rst", tx_valid, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
